// File: rtl/rd_ptr_fwft_handler.sv
// rd_ptr_fwft_handler: async FIFO read-side pointer, RAM read control and two-entry FWFT output stage
module rd_ptr_fwft_handler #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int DATA_W    = 8,
  parameter int AE_THRESH = 2
) (
  input  logic              i_rclk,
  input  logic              i_rrst_n,
  input  logic [PTR_W:0]    i_g_wptr_sync,
  output logic [PTR_W:0]    o_g_rptr,
  output logic [PTR_W-1:0]  o_raddr,
  output logic              o_ren,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic [PTR_W:0]    o_rlevel
);
  localparam int AW = PTR_W + 1;
  logic [PTR_W:0] b_rptr, b_next, w_bin;
  logic head_v, skid_v, inflight, pop, issue, take;
  logic [1:0] credit;
  logic [DATA_W-1:0] head_d, skid_d;
  for (genvar j = 0; j <= PTR_W; j++) begin : g_g2b
    assign w_bin[j] = ^i_g_wptr_sync[PTR_W:j];
  end
  assign b_next = b_rptr + 1'b1;
  assign pop    = head_v & i_rready;
  // words staged or in flight after this edge; never more than the two output slots
  assign credit = 2'(head_v) + 2'(skid_v) + 2'(inflight) - 2'(pop);
  assign issue  = (o_g_rptr != i_g_wptr_sync) & (credit < 2'd2);
  assign take   = ~head_v | pop;
  assign o_ren          = issue;
  assign o_raddr        = b_rptr[PTR_W-1:0];
  assign o_rdata        = head_d;
  assign o_rvalid       = head_v;
  assign o_empty        = ~head_v;
  assign o_rlevel       = w_bin - b_rptr + AW'(head_v) + AW'(skid_v) + AW'(inflight);
  assign o_almost_empty = o_rlevel <= AW'(AE_THRESH);
  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      b_rptr   <= '0;
      o_g_rptr <= '0;
      inflight <= 1'b0;
      head_v   <= 1'b0;
      skid_v   <= 1'b0;
      head_d   <= '0;
      skid_d   <= '0;
    end else begin
      if (issue) begin
        b_rptr   <= b_next;
        o_g_rptr <= b_next ^ (b_next >> 1);
      end
      inflight <= issue;
      if (take) begin
        head_v <= skid_v | inflight;
        head_d <= skid_v ? skid_d : i_rdata;
      end
      skid_v <= take ? skid_v & inflight : skid_v | inflight;
      if (inflight & (~take | skid_v)) skid_d <= i_rdata;
    end
  end
endmodule

// File: tb/tb_rd_ptr_fwft_handler.sv
// tb_rd_ptr_fwft_handler: scoreboard bench with RAM model and independent level/pointer model
module tb_rd_ptr_fwft_handler;
  logic       i_rclk = 1'b0;
  logic       i_rrst_n = 1'b0;
  logic [4:0] i_g_wptr_sync = '0;
  logic [4:0] o_g_rptr;
  logic [3:0] o_raddr;
  logic       o_ren;
  logic [7:0] i_rdata = '0;
  logic [7:0] o_rdata;
  logic       o_rvalid;
  logic       i_rready = 1'b0;
  logic       o_empty;
  logic       o_almost_empty;
  logic [4:0] o_rlevel;

  rd_ptr_fwft_handler #(.DEPTH(16), .DATA_W(8), .AE_THRESH(2)) dut (
    .i_rclk(i_rclk), .i_rrst_n(i_rrst_n), .i_g_wptr_sync(i_g_wptr_sync),
    .o_g_rptr(o_g_rptr), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready), .o_empty(o_empty),
    .o_almost_empty(o_almost_empty), .o_rlevel(o_rlevel)
  );

  always #5 i_rclk = ~i_rclk;

  logic [7:0] mem [16];
  always @(posedge i_rclk) if (o_ren) i_rdata <= mem[o_raddr];

  int checks = 0, errors = 0;
  int wptr = 0, issued = 0, popped = 0, ren_cnt = 0;
  logic [7:0] q[$];
  logic [4:0] prev_g = '0;
  logic s_ren, s_rvalid, s_pop;
  logic [4:0] s_level, s_g;
  logic [7:0] s_rdata;

  typedef struct {
    bit rdy;
    int nw;
    bit exp_rvalid;
    bit exp_ren;
    int exp_level;
  } vec_t;
  vec_t vt[7];

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] word(input int k);
    return 8'(k * 7 + 3);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input bit rdy, input int nw);
    @(negedge i_rclk);
    for (int k = 0; k < nw; k++) begin
      mem[wptr % 16] = word(wptr);
      q.push_back(word(wptr));
      wptr++;
    end
    i_g_wptr_sync = gray(wptr);
    i_rready = rdy;
    #1;
    s_ren = o_ren; s_rvalid = o_rvalid; s_level = o_rlevel; s_g = o_g_rptr; s_rdata = o_rdata;
    s_pop = 1'b0;
    chk("g_rptr", o_g_rptr, gray(issued));
    if (o_g_rptr != prev_g) chk("gray_one_bit", $countones(o_g_rptr ^ prev_g), 1);
    prev_g = o_g_rptr;
    chk("rlevel", o_rlevel, wptr - popped);
    chk("almost_empty", o_almost_empty, (wptr - popped) <= 2);
    chk("empty", o_empty, !o_rvalid);
    if (o_ren) begin
      chk("raddr", o_raddr, issued % 16);
      issued++;
      ren_cnt++;
    end
    if (o_rvalid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        chk("rdata", o_rdata, q[0]);
        if (i_rready) begin
          void'(q.pop_front());
          popped++;
          s_pop = 1'b1;
        end
      end
    end
    @(posedge i_rclk);
  endtask

  initial begin
    int first, last, n, written, max_lvl;
    vt[0] = '{0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0};
    vt[2] = '{0, 0, 0, 0, 0};
    vt[3] = '{1, 1, 0, 1, 1};
    vt[4] = '{1, 0, 0, 0, 1};
    vt[5] = '{1, 0, 1, 0, 1};
    vt[6] = '{1, 0, 0, 0, 0};
    repeat (2) @(posedge i_rclk);
    #1;
    chk("reset_rvalid", o_rvalid, 0);
    chk("reset_empty", o_empty, 1);
    chk("reset_level", o_rlevel, 0);
    chk("reset_ae", o_almost_empty, 1);
    @(negedge i_rclk) i_rrst_n = 1'b1;
    // idle then single word: issue in the write cycle, valid two edges later
    for (int i = 0; i < 7; i++) begin
      step(vt[i].rdy, vt[i].nw);
      chk($sformatf("vec%0d_rvalid", i), s_rvalid, vt[i].exp_rvalid);
      chk($sformatf("vec%0d_ren", i), s_ren, vt[i].exp_ren);
      chk($sformatf("vec%0d_level", i), s_level, vt[i].exp_level);
    end
    step(1, 0);
    chk("single_g_rptr", s_g, 1);
    // eight words, continuous ready: one pop per cycle
    step(1, 8);
    first = -1; last = -1; n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      if (s_pop) begin
        if (first < 0) first = i;
        last = i;
        n++;
      end
    end
    chk("burst_pops", n, 8);
    chk("burst_consecutive", last - first, 7);
    chk("burst_g_rptr", s_g, gray(9));
    // backpressure: only two reads issued, head stable
    ren_cnt = 0;
    step(0, 6);
    repeat (5) step(0, 0);
    chk("bp_ren_count", ren_cnt, 2);
    chk("bp_rvalid", s_rvalid, 1);
    chk("bp_head", s_rdata, word(9));
    chk("bp_level", s_level, 6);
    n = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      step(1, 0);
      if (s_pop) n++;
    end
    chk("bp_drain_pops", n, 6);
    chk("bp_drain_empty", q.size(), 0);
    // wrap streaming with random stalls
    written = 0; max_lvl = 0;
    for (int i = 0; i < 600 && (written < 40 || q.size() > 0); i++) begin
      n = (written < 40 && wptr - issued < 16) ? 1 : 0;
      step($urandom_range(0, 3) != 0, n);
      written += n;
      if (int'(s_level) > max_lvl) max_lvl = int'(s_level);
    end
    chk("wrap_drained", q.size(), 0);
    chk("wrap_written", written, 40);
    chk("wrap_max_level_ok", max_lvl <= 18, 1);
    // asynchronous reset with data staged and in flight
    step(0, 3);
    step(0, 0);
    #3;
    i_rrst_n = 1'b0;
    i_g_wptr_sync = '0;
    #1;
    chk("arst_rvalid", o_rvalid, 0);
    chk("arst_empty", o_empty, 1);
    chk("arst_g_rptr", o_g_rptr, 0);
    chk("arst_level", o_rlevel, 0);
    chk("arst_ae", o_almost_empty, 1);
    wptr = 0; issued = 0; popped = 0; prev_g = '0;
    q.delete();
    @(negedge i_rclk) i_rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("post_rst_rvalid", s_rvalid, 0);
      chk("post_rst_ren", s_ren, 0);
    end
    step(1, 1);
    n = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      step(1, 0);
      if (s_pop) n++;
    end
    chk("post_rst_pop", n, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
